// File: rtl/arch_defs_pkg.sv
// Architecture definitions for the 8-bit SAP-2 style CPU.
// Holds datapath widths, the opcode and controller-state enums, and the
// has_operand() helper shared by the controller and anyone decoding IR.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;
  localparam int RAM_DEPTH  = 256;

  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_LDI  = 8'h10,
    OP_LDA  = 8'h11,
    OP_STA  = 8'h12,
    OP_ADD  = 8'h20,
    OP_SUB  = 8'h21,
    OP_JMP  = 8'h30,
    OP_JZ   = 8'h31,
    OP_JC   = 8'h32,
    OP_OUTA = 8'h40,
    OP_HLT  = 8'hFF
  } opcode_t;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  // Two-byte instructions: the byte after the opcode is an immediate or address.
  function automatic logic has_operand(opcode_t op);
    case (op)
      OP_LDI, OP_LDA, OP_STA, OP_ADD, OP_SUB,
      OP_JMP, OP_JZ, OP_JC: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/computer_if.sv
// Memory bus between the CPU controller (master) and the unified RAM (slave).
//   addr  : byte address
//   wdata : write data, sampled on the rising clock edge when we = 1
//   we    : write enable
//   rdata : combinational read of mem[addr]
interface computer_if;
  logic [arch_defs_pkg::ADDR_WIDTH-1:0] addr;
  logic [arch_defs_pkg::DATA_WIDTH-1:0] wdata;
  logic [arch_defs_pkg::DATA_WIDTH-1:0] rdata;
  logic                                 we;

  modport master (output addr, wdata, we, input rdata);
  modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/ram.sv
// 256 x 8 unified program/data RAM. Not cleared by reset; contents are
// expected to be preloaded (e.g. hierarchical writes to mem) before reset
// is released.
//   clk : write clock
//   bus : slave side of the memory bus (combinational read, sync write)
module ram
  import arch_defs_pkg::*;
(
  input logic       clk,
  computer_if.slave bus
);

  logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

  assign bus.rdata = mem[bus.addr];

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.addr] <= bus.wdata;
  end

  // Simulation aid: list every non-zero location.
  task dump();
    for (int i = 0; i < RAM_DEPTH; i++)
      if (mem[i] != '0) $display("mem[%02h] = %02h", i, mem[i]);
  endtask

endmodule

// File: rtl/register_nbit.sv
// Generic N-bit load-enabled register with asynchronous active-low reset.
//   clk, reset   : clock, async active-low reset (clears to 0)
//   load         : capture data_in on the rising edge
//   data_in      : next value
//   latched_data : current contents
module register_nbit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] latched_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    latched_data <= '0;
    else if (load) latched_data <= data_in;
  end

endmodule

// File: rtl/computer.sv
// Top level of the 8-bit SAP-2 style CPU. A three-state-per-instruction
// controller (fetch / decode / execute) drives PC, IR, OPR, A, flags and the
// OUT register against a unified 256-byte RAM. HLT parks the FSM in S_HALT
// until reset.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   out_val : contents of the OUT register
module computer
  import arch_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] out_val
);

  computer_if bus ();

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  z, c;
  logic                  halt;

  logic [DATA_WIDTH-1:0] ir, opr, a_q, mem_rd;
  logic                  ir_ld, opr_ld, a_ld, out_ld;
  logic [DATA_WIDTH-1:0] a_d;
  logic [DATA_WIDTH:0]   add9, sub9;
  opcode_t               op;

  assign op     = opcode_t'(ir);
  assign mem_rd = bus.rdata;

  ram u_ram (
    .clk (clk),
    .bus (bus)
  );

  // Instruction/operand bytes come from PC; execute-phase accesses use OPR.
  assign bus.addr  = (state == S_EXEC) ? opr : pc;
  assign bus.wdata = a_q;
  assign bus.we    = (state == S_EXEC) && (op == OP_STA);

  // ALU: 9-bit results so bit 8 is carry (ADD) or borrow (SUB).
  assign add9 = {1'b0, a_q} + {1'b0, mem_rd};
  assign sub9 = {1'b0, a_q} - {1'b0, mem_rd};

  assign ir_ld  = (state == S_FETCH);
  assign opr_ld = (state == S_DECODE) && has_operand(op);
  assign out_ld = (state == S_EXEC) && (op == OP_OUTA);

  always_comb begin
    a_ld = 1'b0;
    a_d  = a_q;
    if (state == S_EXEC) begin
      case (op)
        OP_LDI:  begin a_ld = 1'b1; a_d = opr;        end
        OP_LDA:  begin a_ld = 1'b1; a_d = mem_rd;     end
        OP_ADD:  begin a_ld = 1'b1; a_d = add9[7:0];  end
        OP_SUB:  begin a_ld = 1'b1; a_d = sub9[7:0];  end
        default: ;
      endcase
    end
  end

  register_nbit #(.N(DATA_WIDTH)) u_register_IR (
    .clk (clk), .reset (reset), .load (ir_ld),
    .data_in (mem_rd), .latched_data (ir)
  );

  register_nbit #(.N(DATA_WIDTH)) u_register_OPR (
    .clk (clk), .reset (reset), .load (opr_ld),
    .data_in (mem_rd), .latched_data (opr)
  );

  register_nbit #(.N(DATA_WIDTH)) u_register_A (
    .clk (clk), .reset (reset), .load (a_ld),
    .data_in (a_d), .latched_data (a_q)
  );

  register_nbit #(.N(DATA_WIDTH)) u_register_OUT (
    .clk (clk), .reset (reset), .load (out_ld),
    .data_in (a_q), .latched_data (out_val)
  );

  // Controller: state, PC, flags and halt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc    <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
      halt  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (has_operand(op)) pc <= pc + 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (op)
            OP_ADD: begin
              c <= add9[8];
              z <= (add9[7:0] == '0);
            end
            OP_SUB: begin
              c <= ~sub9[8];            // set when no borrow
              z <= (sub9[7:0] == '0);
            end
            OP_JMP: pc <= opr;
            OP_JZ:  if (z) pc <= opr;
            OP_JC:  if (c) pc <= opr;
            OP_HLT: begin
              state <= S_HALT;
              halt  <= 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_computer.sv
// Self-checking bench for computer: directed programs from the test plan plus
// randomized forward-branching programs, all checked against an ISA-level
// interpreter kept in the bench.
module tb_computer;
  import arch_defs_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] out_val;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [256];
  logic [7:0] mm  [256];
  logic [7:0] ea, eout, epc;
  logic       ez, ec;
  int         en;

  logic [7:0] tbl [10] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h20,
                           8'h21, 8'h31, 8'h32, 8'h40, 8'h77};

  computer dut (
    .clk     (clk),
    .reset   (reset),
    .out_val (out_val)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic two_byte(input logic [7:0] op);
    return op inside {8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h30, 8'h31, 8'h32};
  endfunction

  // Reference: interpret the program at ISA level, counting instructions
  // (HLT included); each instruction costs three clocks on the DUT.
  task automatic model_run();
    logic [7:0] p, op, arg;
    int t;
    mm = img;
    ea = 0; eout = 0; ez = 0; ec = 0; p = 0; en = 0; epc = 0;
    for (int s = 0; s < 2000; s++) begin
      op = mm[p]; p = p + 8'd1; en++;
      arg = 0;
      if (two_byte(op)) begin arg = mm[p]; p = p + 8'd1; end
      case (op)
        8'h10: ea = arg;
        8'h11: ea = mm[arg];
        8'h12: mm[arg] = ea;
        8'h20: begin
          t  = int'(ea) + int'(mm[arg]);
          ec = (t > 255);
          ea = 8'(t % 256);
          ez = (ea == 0);
        end
        8'h21: begin
          ec = (ea >= mm[arg]);
          t  = int'(ea) - int'(mm[arg]) + 256;
          ea = 8'(t % 256);
          ez = (ea == 0);
        end
        8'h30: p = arg;
        8'h31: if (ez) p = arg;
        8'h32: if (ec) p = arg;
        8'h40: eout = ea;
        8'hFF: begin epc = p; break; end
        default: ;
      endcase
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic put(input int addr, input logic [7:0] b);
    img[addr] = b;
  endtask

  // Hold reset, preload RAM, run the model, check reset state.
  task automatic start_prog(input string name);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.u_ram.mem[i] = img[i];
    model_run();
    #1;
    chk({name, ":rst_a"},    32'(dut.u_register_A.latched_data), 32'h0);
    chk({name, ":rst_out"},  32'(out_val), 32'h0);
    chk({name, ":rst_pc"},   32'(dut.pc), 32'h0);
    chk({name, ":rst_halt"}, 32'(dut.halt), 32'h0);
    chk({name, ":rst_zc"},   32'({dut.z, dut.c}), 32'h0);
  endtask

  // Release reset, run to halt, compare with the model, then check HLT holds.
  task automatic finish_check(input string name);
    int cyc = 0;
    int diff = 0;
    reset = 1'b1;
    while (!dut.halt && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    chk({name, ":halt"},   32'(dut.halt), 32'h1);
    chk({name, ":cycles"}, 32'(cyc), 32'(3 * en));
    chk({name, ":a"},      32'(dut.u_register_A.latched_data), 32'(ea));
    chk({name, ":outreg"}, 32'(dut.u_register_OUT.latched_data), 32'(eout));
    chk({name, ":out_val"},32'(out_val), 32'(eout));
    chk({name, ":zc"},     32'({dut.z, dut.c}), 32'({ez, ec}));
    chk({name, ":pc"},     32'(dut.pc), 32'(epc));
    for (int i = 0; i < 256; i++) if (dut.u_ram.mem[i] !== mm[i]) diff++;
    chk({name, ":mem_diffs"}, 32'(diff), 32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk({name, ":hold_pc"},   32'(dut.pc), 32'(epc));
    chk({name, ":hold_a"},    32'(dut.u_register_A.latched_data), 32'(ea));
    chk({name, ":hold_out"},  32'(out_val), 32'(eout));
    chk({name, ":hold_halt"}, 32'(dut.halt), 32'h1);
    chk({name, ":hold_st"},   32'(dut.state), 32'(S_HALT));
  endtask

  task automatic gen_random();
    logic [7:0] ops [17];
    logic [7:0] args [17];
    int adr [17];
    int tgt [17];
    int n, pos, k;
    clear_img();
    n = $urandom_range(8, 16);
    pos = 0;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      ops[i] = tbl[k];
      adr[i] = pos;
      pos += two_byte(ops[i]) ? 2 : 1;
      args[i] = 8'h80 + 8'($urandom_range(0, 15));
      if (ops[i] == 8'h10) args[i] = 8'($urandom_range(0, 255));
      tgt[i] = $urandom_range(i + 1, n);
    end
    adr[n] = pos;
    ops[n] = 8'hFF;
    for (int i = 0; i < n; i++) begin
      put(adr[i], ops[i]);
      if (ops[i] inside {8'h31, 8'h32}) put(adr[i] + 1, 8'(adr[tgt[i]]));
      else if (two_byte(ops[i]))        put(adr[i] + 1, args[i]);
    end
    put(adr[n], 8'hFF);
    for (int i = 8'h80; i < 8'h90; i++) put(i, 8'($urandom_range(0, 255)));
  endtask

  initial begin
    // OUTA
    clear_img();
    put(0, 8'h10); put(1, 8'h09); put(2, 8'h40); put(3, 8'hFF);
    start_prog("outa");
    chk("outa:model_out", 32'(eout), 32'h09);
    finish_check("outa");

    // LDA / ADD / STA
    clear_img();
    put(0, 8'h11); put(1, 8'h10); put(2, 8'h20); put(3, 8'h11);
    put(4, 8'h12); put(5, 8'h12); put(6, 8'h40); put(7, 8'hFF);
    put(8'h10, 8'h05); put(8'h11, 8'h03);
    start_prog("ldaddsta");
    chk("ldaddsta:model_mem12", 32'(mm[8'h12]), 32'h08);
    finish_check("ldaddsta");

    // Flags / JZ taken
    clear_img();
    put(0, 8'h10); put(1, 8'hFF); put(2, 8'h20); put(3, 8'h20);
    put(4, 8'h31); put(5, 8'h0A); put(6, 8'h10); put(7, 8'h00);
    put(8, 8'h40); put(9, 8'hFF);
    put(10, 8'h10); put(11, 8'h2A); put(12, 8'h40); put(13, 8'hFF);
    put(8'h20, 8'h01);
    start_prog("jz");
    chk("jz:model_out", 32'(eout), 32'h2A);
    finish_check("jz");

    // SUB with borrow, JC not taken
    clear_img();
    put(0, 8'h10); put(1, 8'h03); put(2, 8'h21); put(3, 8'h20);
    put(4, 8'h32); put(5, 8'h08); put(6, 8'h40); put(7, 8'hFF);
    put(8, 8'h10); put(9, 8'h11); put(10, 8'h40); put(11, 8'hFF);
    put(8'h20, 8'h05);
    start_prog("sub");
    chk("sub:model_out", 32'(eout), 32'hFE);
    finish_check("sub");

    // Unknown opcode as NOP, JMP
    clear_img();
    put(0, 8'h10); put(1, 8'h07); put(2, 8'h77); put(3, 8'h30);
    put(4, 8'h07); put(5, 8'hFF); put(6, 8'hFF); put(7, 8'h40); put(8, 8'hFF);
    start_prog("nop_jmp");
    finish_check("nop_jmp");

    // PC wraps 0xFF -> 0x00 (OUTA at 0xFF, then JC at 0x00 taken)
    clear_img();
    put(0, 8'h32); put(1, 8'h10); put(2, 8'h10); put(3, 8'hFF);
    put(4, 8'h20); put(5, 8'h30); put(6, 8'h30); put(7, 8'hFD);
    put(8'h10, 8'hFF); put(8'h30, 8'h01);
    put(8'hFD, 8'h10); put(8'hFE, 8'h5A); put(8'hFF, 8'h40);
    start_prog("pcwrap");
    chk("pcwrap:model_pc", 32'(epc), 32'h11);
    finish_check("pcwrap");

    // Async reset during S_EXEC of the second LDI
    clear_img();
    put(0, 8'h10); put(1, 8'h09); put(2, 8'h40); put(3, 8'h10);
    put(4, 8'h05); put(5, 8'h40); put(6, 8'hFF);
    start_prog("arst");
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("arst:pre_state", 32'(dut.state), 32'(S_EXEC));
    chk("arst:pre_a",     32'(dut.u_register_A.latched_data), 32'h09);
    chk("arst:pre_pc",    32'(dut.pc), 32'h05);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst:a",   32'(dut.u_register_A.latched_data), 32'h0);
    chk("arst:out", 32'(out_val), 32'h0);
    chk("arst:pc",  32'(dut.pc), 32'h0);
    chk("arst:st",  32'(dut.state), 32'(S_FETCH));
    #2;
    finish_check("arst");

    // Randomized programs
    for (int r = 0; r < 8; r++) begin
      gen_random();
      start_prog($sformatf("rand%0d", r));
      finish_check($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/computer.md
Name: computer

Overview:
- Top level of the 8-bit SAP-2-style teaching CPU: multi-cycle FSM controller, PC, IR, operand register, accumulator A, flags, 256-byte unified program/data RAM and an output register.
- Executes the program preloaded into RAM from address 0x00 and drives out_val from the OUT register.
- Stops at HLT and stays stopped until reset.

Parameters:
- none (widths come from arch_defs_pkg: DATA_WIDTH = 8, ADDR_WIDTH = 8, RAM_DEPTH = 256)

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- out_val  output  DATA_WIDTH  current contents of the OUT register

Behaviour:
- Clocking: one clock, clk. reset is asynchronous and active-low.
- Reset state:
  - PC = 0x00, IR = 0x00, OPR = 0x00, A = 0x00, OUT = 0x00 (so out_val = 0x00).
  - Z = 0, C = 0, halt = 0, FSM in S_FETCH.
  - RAM contents are not cleared.
  - Reset asserted mid-instruction aborts the instruction immediately.
- Required internal hierarchy, used by benches:
  - u_ram.mem[0:255], 8-bit words, preloadable by $readmemh.
  - u_ram task dump() prints all non-zero locations.
  - u_register_A.latched_data is the accumulator.
  - u_register_OUT.latched_data is the output register.
  - Top-level net halt is 1 while halted.
- RAM: combinational read of mem[addr]; synchronous write on a rising clk edge when the write enable is high.
- FSM per instruction:
  - S_FETCH: IR <= mem[PC]; PC <= PC+1.
  - S_DECODE: if the opcode takes an operand, OPR <= mem[PC] and PC <= PC+1; else no action. Next state is S_EXEC.
  - S_EXEC: perform the operation, then return to S_FETCH.
  - S_HALT: absorbing; halt = 1; nothing changes.
  - Every instruction takes 3 cycles. HLT reaches S_HALT at the end of its S_EXEC.
- Opcodes (operand byte follows where noted):
  - 0x00 NOP.
  - 0x10 LDI imm: A <= imm.
  - 0x11 LDA addr: A <= mem[addr].
  - 0x12 STA addr: mem[addr] <= A.
  - 0x20 ADD addr: A <= A + mem[addr]; C = carry out; Z = (result == 0).
  - 0x21 SUB addr: A <= A - mem[addr]; C = 1 when no borrow (A >= operand); Z updated.
  - 0x30 JMP addr: PC <= addr.
  - 0x31 JZ addr: PC <= addr if Z.
  - 0x32 JC addr: PC <= addr if C.
  - 0x40 OUTA: OUT <= A.
  - 0xFF HLT.
  - Any other opcode executes as a 1-byte NOP.
- Arithmetic is 8-bit and wraps modulo 256.
- Only ADD and SUB update Z and C. LDI, LDA and OUTA leave the flags unchanged.
- PC wraps from 0xFF to 0x00.
- OUT holds its value until the next OUTA. A holds its value through OUTA.

Decomposition:
- arch_defs_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, RAM_DEPTH.
  - opcode_t enum with all opcodes above.
  - state_t enum: S_FETCH, S_DECODE, S_EXEC, S_HALT.
  - Helper function has_operand(opcode_t).
- Sub-modules:
  - register_nbit (parameter N; ports clk, reset, load, data_in, latched_data), instantiated as u_register_A and u_register_OUT, plus IR and OPR.
  - ram (u_ram) with mem array and dump task.
- Controller, PC, flags and ALU stay in computer.

Test Plan:
- OUTA: RAM = 10 09 40 FF.
  - After reset: A = 0x00, out_val = 0x00.
  - Within 50 cycles halt = 1, A = 0x09, OUT.latched_data = 0x09, out_val = 0x09.
- LDA/ADD/STA: RAM = 11 10 20 11 12 12 40 FF, mem[0x10] = 0x05, mem[0x11] = 0x03.
  - Ends with A = 0x08, mem[0x12] = 0x08, out_val = 0x08.
- Flags/branch: LDI 0xFF, ADD (operand 0x01), JZ to an LDI 0x2A / OUTA / HLT block.
  - C = 1, Z = 1, branch taken, out_val = 0x2A.
- SUB no-branch: LDI 0x03, SUB (operand 0x05), JC skip, OUTA, HLT.
  - A = 0xFE, C = 0, JC not taken, out_val = 0xFE.
- HLT persistence: after halt, run 20 more cycles.
  - PC, A and OUT unchanged; an unknown opcode (0x77) placed before HLT behaves as NOP.
- Async reset mid-run: pull reset low during S_EXEC of LDI.
  - A, OUT and PC return to 0x00 immediately, without a clock edge; after release the program reruns to the same final values.
